// File: rtl/riscv_pkg.sv
// Shared types and constants for the multicycle RV32I control path.
// Holds the state, ALU-operation and opcode definitions used by controller and decoder.
package riscv_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alucontrol_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } statetype;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_FUNCT = 2'b10
    } aluop_t;

    // Immediate format follows the opcode alone, independent of FSM state.
    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:  imm_sel = 2'b01;
            OP_BRANCH: imm_sel = 2'b10;
            OP_JAL:    imm_sel = 2'b11;
            default:   imm_sel = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// Combinational ALU decoder: maps the controller's ALU operation class and
// instruction funct fields onto the 3-bit ALU control code.
module riscv_alu_decoder
    import riscv_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        op5,
    output alucontrol_t alucontrol,
    output logic        funct_illegal
);

    // sltu (funct3=011) has no ALU code; the controller traps it in DECODE.
    assign funct_illegal = (funct3 == 3'b011);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            AOP_ADD: alucontrol = ALU_ADD;
            AOP_SUB: alucontrol = ALU_SUB;
            AOP_FUNCT: begin
                case (funct3)
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alucontrol = ALU_SLL;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b100:  alucontrol = ALU_XOR;
                    3'b101:  alucontrol = ALU_SRL;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle control FSM for the RV32I subset core: decodes the instruction
// register fields into one control bundle per cycle for the datapath.
module riscv_mc_controller
    import riscv_pkg::*;
#(
    parameter statetype RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic [1:0] resultsrc,
    output logic [2:0] alucontrol,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] immsrc,
    output logic       regwrite,
    output logic       illegal,
    output logic [3:0] state
);

    statetype    r_state;
    statetype    w_next;
    statetype    w_out_state;
    logic        w_dec_illegal;
    logic        w_funct_illegal;
    aluop_t      w_aluop;
    alucontrol_t w_alucontrol;
    logic        w_pcupdate;
    logic        w_branch;
    logic        w_adrsrc;
    logic        w_memwrite;
    logic        w_irwrite;
    logic        w_regwrite;
    logic [1:0]  w_resultsrc;
    logic [1:0]  w_alusrca;
    logic [1:0]  w_alusrcb;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = S_FETCH;
        w_dec_illegal = 1'b0;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R: begin
                        w_dec_illegal = w_funct_illegal;
                        w_next        = w_funct_illegal ? S_FETCH : S_EXECUTER;
                    end
                    OP_I: begin
                        w_dec_illegal = w_funct_illegal;
                        w_next        = w_funct_illegal ? S_FETCH : S_EXECUTEI;
                    end
                    OP_BRANCH: begin
                        w_dec_illegal = (funct3 != 3'b000);
                        w_next        = (funct3 == 3'b000) ? S_BEQ : S_FETCH;
                    end
                    OP_JAL:  w_next = S_JAL;
                    default: w_dec_illegal = 1'b1;
                endcase
            end
            S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = S_MEMWB;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_JAL:      w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    // Under reset the datapath selects show FETCH values; enables are masked below.
    assign w_out_state = reset ? S_FETCH : r_state;

    always_comb begin
        w_pcupdate  = 1'b0;
        w_branch    = 1'b0;
        w_adrsrc    = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_regwrite  = 1'b0;
        w_resultsrc = 2'b00;
        w_alusrca   = 2'b00;
        w_alusrcb   = 2'b00;
        w_aluop     = AOP_ADD;
        case (w_out_state)
            S_FETCH: begin
                w_irwrite   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                w_pcupdate  = 1'b1;
            end
            S_DECODE: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
            end
            S_MEMADR: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
            end
            S_MEMREAD: w_adrsrc = 1'b1;
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTER: begin
                w_alusrca = 2'b10;
                w_aluop   = AOP_FUNCT;
            end
            S_EXECUTEI: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_aluop   = AOP_FUNCT;
            end
            S_ALUWB: w_regwrite = 1'b1;
            S_BEQ: begin
                w_alusrca = 2'b10;
                w_aluop   = AOP_SUB;
                w_branch  = 1'b1;
            end
            S_JAL: begin
                w_alusrca  = 2'b01;
                w_alusrcb  = 2'b10;
                w_pcupdate = 1'b1;
            end
            default: ;
        endcase
    end

    riscv_alu_decoder u_alu_decoder (
        .aluop         (w_aluop),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .op5           (op[5]),
        .alucontrol    (w_alucontrol),
        .funct_illegal (w_funct_illegal)
    );

    assign pcwrite    = ~reset & (w_pcupdate | (w_branch & zero));
    assign irwrite    = ~reset & w_irwrite;
    assign regwrite   = ~reset & w_regwrite;
    assign memwrite   = ~reset & w_memwrite;
    assign illegal    = ~reset & (r_state == S_DECODE) & w_dec_illegal;
    assign adrsrc     = w_adrsrc;
    assign resultsrc  = w_resultsrc;
    assign alusrca    = w_alusrca;
    assign alusrcb    = w_alusrcb;
    assign alucontrol = w_alucontrol;
    assign immsrc     = imm_sel(op);
    assign state      = r_state;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Cycle-level scoreboard bench for the multicycle controller: each driven cycle
// pushes its expected control bundle, a negedge monitor pops and compares it.
module tb_riscv_mc_controller;

    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2,
                           ST_MEMREAD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWRITE = 4'd5,
                           ST_EXECR = 4'd6, ST_EXECI = 4'd7, ST_ALUWB = 4'd8,
                           ST_BEQ = 4'd9, ST_JAL = 4'd10;
    localparam logic [6:0] O_LW = 7'b0000011, O_SW = 7'b0100011, O_R = 7'b0110011,
                           O_I = 7'b0010011, O_BR = 7'b1100011, O_JAL = 7'b1101111,
                           O_SYS = 7'b1110011;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [2:0] alu;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] im;
        logic       rw;
        logic       ill;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    obs_t  exp_q[$];
    string name_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    riscv_mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .pcwrite    (pcwrite),
        .adrsrc     (adrsrc),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .resultsrc  (resultsrc),
        .alucontrol (alucontrol),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .immsrc     (immsrc),
        .regwrite   (regwrite),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        obs_t  got;
        obs_t  e;
        string nm;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {state, pcwrite, adrsrc, memwrite, irwrite, resultsrc, alucontrol,
                   alusrca, alusrcb, immsrc, regwrite, illegal};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL %s: got state=%0d pcw=%b adr=%b mw=%b irw=%b rs=%b alu=%b sa=%b sb=%b imm=%b rw=%b ill=%b, expected state=%0d pcw=%b adr=%b mw=%b irw=%b rs=%b alu=%b sa=%b sb=%b imm=%b rw=%b ill=%b",
                         nm, got.st, got.pcw, got.adr, got.mw, got.irw, got.rs, got.alu, got.sa,
                         got.sb, got.im, got.rw, got.ill, e.st, e.pcw, e.adr, e.mw, e.irw, e.rs,
                         e.alu, e.sa, e.sb, e.im, e.rw, e.ill);
            end
        end
    end

    function automatic obs_t mk(input logic [3:0] st, input logic pcw, input logic adr,
                                input logic mw, input logic irw, input logic [1:0] rs,
                                input logic [2:0] alu, input logic [1:0] sa,
                                input logic [1:0] sb, input logic [1:0] im,
                                input logic rw, input logic ill);
        mk = {st, pcw, adr, mw, irw, rs, alu, sa, sb, im, rw, ill};
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        if (o == O_SW)       exp_imm = 2'b01;
        else if (o == O_BR)  exp_imm = 2'b10;
        else if (o == O_JAL) exp_imm = 2'b11;
        else                 exp_imm = 2'b00;
    endfunction

    function automatic logic [2:0] exp_funct(input logic [2:0] f3, input logic f7, input logic op5);
        case (f3)
            3'b000:  exp_funct = (op5 && f7) ? 3'b001 : 3'b000;
            3'b001:  exp_funct = 3'b110;
            3'b010:  exp_funct = 3'b101;
            3'b100:  exp_funct = 3'b100;
            3'b101:  exp_funct = 3'b111;
            3'b110:  exp_funct = 3'b011;
            3'b111:  exp_funct = 3'b010;
            default: exp_funct = 3'b000;
        endcase
    endfunction

    // Expected bundle while reset is held: enables off, selects at their FETCH values.
    function automatic obs_t reset_vec(input logic [3:0] st, input logic [1:0] im);
        reset_vec = mk(st, 0, 0, 0, 0, 2'b10, 3'b000, 2'b00, 2'b10, im, 0, 0);
    endfunction

    // Runs one instruction from FETCH. zv is zero in BEQ (its inverse elsewhere);
    // rst_at>0 asserts reset for two cycles starting at that cycle number.
    task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic zv, input string nm, input int rst_at);
        obs_t       seq[$];
        logic [1:0] im;
        logic [2:0] fa;
        logic       legal;
        op = o; funct3 = f3; funct7b5 = f7;
        im = exp_imm(o);
        fa = exp_funct(f3, f7, o[5]);
        if (o == O_LW || o == O_SW || o == O_JAL) legal = 1'b1;
        else if (o == O_R || o == O_I)            legal = (f3 != 3'b011);
        else if (o == O_BR)                       legal = (f3 == 3'b000);
        else                                      legal = 1'b0;
        seq.push_back(mk(ST_FETCH, 1, 0, 0, 1, 2'b10, 3'b000, 2'b00, 2'b10, im, 0, 0));
        seq.push_back(mk(ST_DECODE, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b01, im, 0, !legal));
        if (legal) begin
            if (o == O_LW) begin
                seq.push_back(mk(ST_MEMADR, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 2'b01, im, 0, 0));
                seq.push_back(mk(ST_MEMREAD, 0, 1, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, im, 0, 0));
                seq.push_back(mk(ST_MEMWB, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 2'b00, im, 1, 0));
            end else if (o == O_SW) begin
                seq.push_back(mk(ST_MEMADR, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 2'b01, im, 0, 0));
                seq.push_back(mk(ST_MEMWRITE, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 2'b00, im, 0, 0));
            end else if (o == O_R) begin
                seq.push_back(mk(ST_EXECR, 0, 0, 0, 0, 2'b00, fa, 2'b10, 2'b00, im, 0, 0));
                seq.push_back(mk(ST_ALUWB, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, im, 1, 0));
            end else if (o == O_I) begin
                seq.push_back(mk(ST_EXECI, 0, 0, 0, 0, 2'b00, fa, 2'b10, 2'b01, im, 0, 0));
                seq.push_back(mk(ST_ALUWB, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, im, 1, 0));
            end else if (o == O_BR) begin
                seq.push_back(mk(ST_BEQ, zv, 0, 0, 0, 2'b00, 3'b001, 2'b10, 2'b00, im, 0, 0));
            end else begin
                seq.push_back(mk(ST_JAL, 1, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b10, im, 0, 0));
                seq.push_back(mk(ST_ALUWB, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, im, 1, 0));
            end
        end
        for (int i = 0; i < seq.size(); i++) begin
            if (rst_at == i + 1) begin
                reset = 1'b1; zero = 1'b1;
                exp_q.push_back(reset_vec(seq[i].st, im));
                name_q.push_back($sformatf("%s rst1", nm));
                @(posedge clk); #1;
                exp_q.push_back(reset_vec(ST_FETCH, im));
                name_q.push_back($sformatf("%s rst2", nm));
                @(posedge clk); #1;
                reset = 1'b0;
                break;
            end
            reset = 1'b0;
            zero  = (seq[i].st == ST_BEQ) ? zv : ~zv;
            exp_q.push_back(seq[i]);
            name_q.push_back($sformatf("%s c%0d", nm, i + 1));
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(reset_vec(ST_FETCH, 2'b00));
            name_q.push_back($sformatf("power-on reset c%0d", i + 1));
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_load;
        issue(O_LW, 3'b010, 1'b0, 1'b1, "lw", 0);
    endtask

    task automatic test_store;
        issue(O_SW, 3'b010, 1'b1, 1'b1, "sw", 0);
    endtask

    task automatic test_rtype;
        issue(O_R, 3'b000, 1'b1, 1'b1, "r sub", 0);
        issue(O_R, 3'b000, 1'b0, 1'b1, "r add", 0);
        issue(O_R, 3'b111, 1'b0, 1'b1, "r and", 0);
        issue(O_R, 3'b001, 1'b0, 1'b1, "r sll", 0);
        issue(O_R, 3'b110, 1'b0, 1'b1, "r or", 0);
        issue(O_R, 3'b100, 1'b0, 1'b1, "r xor", 0);
        issue(O_R, 3'b010, 1'b0, 1'b1, "r slt", 0);
        issue(O_R, 3'b101, 1'b1, 1'b1, "r srl", 0);
    endtask

    task automatic test_itype;
        issue(O_I, 3'b101, 1'b1, 1'b1, "i srli", 0);
        issue(O_I, 3'b000, 1'b1, 1'b1, "i addi f7b5", 0);
        issue(O_I, 3'b111, 1'b0, 1'b1, "i andi", 0);
    endtask

    task automatic test_beq;
        issue(O_BR, 3'b000, 1'b0, 1'b1, "beq taken", 0);
        issue(O_BR, 3'b000, 1'b0, 1'b0, "beq not taken", 0);
    endtask

    task automatic test_jal;
        issue(O_JAL, 3'b000, 1'b0, 1'b0, "jal", 0);
    endtask

    task automatic test_illegal;
        issue(O_SYS, 3'b000, 1'b0, 1'b1, "illegal system", 0);
        issue(O_R, 3'b011, 1'b0, 1'b1, "illegal r sltu", 0);
        issue(O_I, 3'b011, 1'b0, 1'b1, "illegal i sltiu", 0);
        issue(O_BR, 3'b001, 1'b0, 1'b1, "illegal bne", 0);
    endtask

    task automatic test_reset_mid;
        issue(O_SW, 3'b010, 1'b0, 1'b1, "sw reset in memwrite", 4);
        issue(O_LW, 3'b010, 1'b0, 1'b1, "lw reset in memwb", 5);
        issue(O_BR, 3'b000, 1'b0, 1'b1, "beq reset in beq", 3);
        issue(O_SYS, 3'b000, 1'b0, 1'b1, "illegal reset in decode", 2);
    endtask

    task automatic test_back_to_back;
        logic [6:0] ops [6];
        ops[0] = O_LW; ops[1] = O_SW; ops[2] = O_R; ops[3] = O_I; ops[4] = O_BR; ops[5] = O_JAL;
        for (int n = 0; n < 12; n++) begin
            issue(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $sformatf("b2b %0d", n), 0);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_rtype();
        test_itype();
        test_beq();
        test_jal();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        @(negedge clk);
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/riscv_mc_controller.md
Name: riscv_mc_controller

Overview:
- Multicycle control FSM for the RV32I subset core; the producing end of the ALU interface.
- Drives the 3-bit ALU operation code plus operand-select, memory, register-file and PC enables.
- Consumes the ALU zero flag to resolve branches.
- Sits beside the datapath: instruction-register fields in, one control bundle per cycle out.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset (fixed; exposed for documentation only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  7  instr[6:0] from instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU result==0.
- pcwrite  out  1  PC load enable.
- adrsrc  out  1  0=PC, 1=ALUOut to memory address.
- memwrite  out  1  data memory write.
- irwrite  out  1  instruction register and oldPC load.
- resultsrc  out  2  00 ALUOut, 01 mem data, 10 ALU result.
- alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
- alusrca  out  2  00 PC, 01 oldPC, 10 rs1.
- alusrcb  out  2  00 rs2, 01 imm, 10 const 4.
- immsrc  out  2  00 I, 01 S, 10 B, 11 J.
- regwrite  out  1  register file write.
- illegal  out  1  one-cycle pulse, unsupported instruction.
- state  out  4  current state, debug.

Behaviour:
- Moore FSM; outputs decode from the state register, except:
  - pcwrite = pcupdate | (branch & zero).
  - immsrc decodes combinationally from op: lw/I-ALU 00, sw 01, beq 10, jal 11, else 00.
- Reset:
  - At a clk edge with reset=1, state <= FETCH.
  - While reset=1, pcwrite, irwrite, regwrite, memwrite and illegal are forced 0.
  - All other outputs take their FETCH values.
- Reset mid-instruction aborts with no partial write in the cycle following the reset edge.
- States and transitions (unlisted outputs are 0 / 00):
  - FETCH: adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, aluop=add, resultsrc=10, pcupdate=1. Next: DECODE.
  - DECODE: alusrca=01, alusrcb=01, aluop=add (branch target into ALUOut).
    - op 0000011 or 0100011 -> MEMADR.
    - op 0110011 -> EXECUTER.
    - op 0010011 -> EXECUTEI.
    - op 1100011 with funct3=000 -> BEQ.
    - op 1101111 -> JAL.
    - Anything else, or ALU op with funct3=011 -> FETCH with illegal=1 for this cycle.
  - MEMADR: alusrca=10, alusrcb=01, aluop=add. Next: MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: resultsrc=00, adrsrc=1. Next: MEMWB.
  - MEMWB: resultsrc=01, regwrite=1. Next: FETCH.
  - MEMWRITE: resultsrc=00, adrsrc=1, memwrite=1. Next: FETCH.
  - EXECUTER: alusrca=10, alusrcb=00, aluop=funct. Next: ALUWB.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=funct. Next: ALUWB.
  - ALUWB: resultsrc=00, regwrite=1. Next: FETCH.
  - BEQ: alusrca=10, alusrcb=00, aluop=sub, resultsrc=00, branch=1. Next: FETCH.
  - JAL: alusrca=01, alusrcb=10, aluop=add, resultsrc=00, pcupdate=1. Next: ALUWB.
- Latency in cycles: lw 5, sw 4, R 4, I 4, beq 3, jal 4.
- aluop=funct mapping from funct3:
  - 000: sub if op[5]&funct7b5, else add.
  - 001 -> sll; 010 -> slt; 100 -> xor; 101 -> srl (funct7b5 ignored, no sra); 110 -> or; 111 -> and.
- Unused state codes -> FETCH next cycle, all enables 0.
- zero is sampled only in BEQ.

Decomposition:
- Package riscv_pkg holds:
  - alucontrol enum (ALU_ADD..ALU_SRL, values above).
  - opcode constants OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL.
  - statetype enum, 4-bit.
  - aluop enum {AOP_ADD, AOP_SUB, AOP_FUNCT}.
- One sub-module, riscv_alu_decoder (combinational).
  - Inputs: aluop, funct3, funct7b5, op5.
  - Outputs: alucontrol, funct_illegal.

Test Plan:
- reset=1 for 2 cycles during memwrite-asserting state -> state=FETCH, memwrite=regwrite=pcwrite=irwrite=0 while reset; first post-reset cycle irwrite=1, pcwrite=1, alucontrol=000.
- lw (op=0000011) -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; regwrite=1 only in cycle 5 with resultsrc=01; adrsrc=1 in cycles 4.
- R-type funct3=000, funct7b5=1 -> alucontrol=001 in EXECUTER; funct3=111 -> 010; funct3=001 -> 110; I-type funct3=101, funct7b5=1 -> 111.
- beq, zero=1 in BEQ -> pcwrite=1, alucontrol=001, back to FETCH; zero=0 -> pcwrite=0; total 3 cycles.
- jal -> JAL asserts pcwrite=1, alusrca=01, alusrcb=10; ALUWB regwrite=1 next; 4 cycles.
- op=1110011 or R-type funct3=011 -> illegal=1 in DECODE cycle, next state FETCH, no regwrite/memwrite.
